max11046_serial_rx: RTL and testbench
=====================================

// Module: max11046_serial_rx
// PURPOSE
//   Serial-to-parallel receiver for the MAX11046 serial sample link: receives the LSB-first
//   bit stream produced by the ADC-side shifter and rebuilds WIDTH-bit sample words.
//   Framed by endof_con (low = load/idle, high = shift). Completed words are held in a
//   one-word output register with valid/ready handshake toward the sample buffer.
// PARAMETERS
//   WIDTH      16   bits per frame/word
//   CNT_W      5    bit-counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//   Clock      in   1      single clock, all logic on rising edge
//   Reset      in   1      asynchronous, active-high
//   ClockEn    in   1      bit strobe; Sin sampled only when 1
//   endof_con  in   1      frame gate: 0 = idle/load, 1 = frame in progress
//   Sin        in   1      serial data, LSB first
//   Dout       out  WIDTH  received word (stable while Dvalid=1)
//   Dvalid     out  1      Dout holds an unconsumed word
//   Dready     in   1      consumer accepts word when Dvalid&Dready on a rising edge
//   Busy       out  1      1 in SHIFT or HOLD
//   FrameErr   out  1      one-cycle pulse: frame ended with fewer than WIDTH bits
//   Overrun    out  1      sticky: word completed while the previous word was unconsumed
// BEHAVIOUR
//   Reset (async): state=IDLE, shreg=0, bitcnt=0, Dout=0, Dvalid=0, FrameErr=0, Overrun=0.
//   States:
//     IDLE : endof_con==1 -> SHIFT, bitcnt=0. The edge that enters SHIFT also samples Sin
//            if ClockEn==1 (that is bit 0).
//     SHIFT: on ClockEn==1: shreg <= {Sin, shreg[WIDTH-1:1]}, bitcnt++.
//            Sample that makes bitcnt reach WIDTH: commit {Sin, shreg[WIDTH-1:1]} to
//            Dout on the same edge; Dvalid=1 from the next cycle (1-cycle latency from the
//            last bit); -> HOLD.
//            endof_con==0 before WIDTH bits: FrameErr=1 for one cycle; partial word
//            discarded; Dout/Dvalid untouched; -> IDLE.
//     HOLD : further bits ignored; endof_con==0 -> IDLE. Never raises FrameErr.
//   Handshake: Dvalid clears on the edge where Dvalid&Dready==1. Commit with Dvalid=1 and
//     Dready=0: new word overwrites Dout, Dvalid stays 1, Overrun set (sticky until Reset).
//     Commit coinciding with Dready=1: old word is consumed, new word loaded, Dvalid stays
//     1, no Overrun.
//   ClockEn==0: state, shreg and bitcnt hold; handshake and endof_con-driven transitions
//     still act every cycle.
//   Busy = (state != IDLE). Reset mid-frame discards all partial data immediately.
//   bitcnt saturates at WIDTH and never wraps.
// CONFIGURATION
//   `MAX11046_RX_ERRCNT_EN defined: adds output ports FrameErrCnt[7:0] and OverrunCnt[7:0].
//     Each counts its events, saturates at 8'hFF, and clears on Reset. Overrun still
//     stays sticky.
//   Not defined: neither port exists and no counter logic is built. All other behaviour
//     is identical.
// TESTING
//   1 Reset with Dready=1, then one frame: 16 bits of 16'hA5C3 LSB first, ClockEn=1
//     -> Dout=16'hA5C3, Dvalid=1 one cycle after bit 15, then cleared by Dready.
//   2 ClockEn toggling 1/0 during a frame of 16'h8001 -> Dout=16'h8001; Busy=1 through
//     the frame.
//   3 endof_con drops after 9 bits -> FrameErr pulse of exactly 1 cycle; Dvalid stays 0;
//     state returns to IDLE; next full frame of 16'h1234 is received correctly.
//   4 Dready=0; frames 16'h0001 then 16'hFFFF -> Dout=16'hFFFF, Overrun=1; then Dready=1
//     -> Dvalid=0 and Overrun still 1.
//   5 Reset asserted at bit 7 of a frame -> all outputs 0 immediately; after release,
//     frame 16'h5A5A -> Dout=16'h5A5A.
//   6 With `MAX11046_RX_ERRCNT_EN: 300 short frames -> FrameErrCnt=8'hFF (saturated);
//     Reset -> 0.

Source files
------------

// File: rtl/max11046_serial_rx_if.sv
// rtl/max11046_serial_rx_if.sv - MAX11046 serial receiver link/handshake signal bundle
// Optional counter signals exist only when MAX11046_RX_ERRCNT_EN is defined.
interface max11046_serial_rx_if #(
    parameter int WIDTH = 16
);
    logic             ClockEn;
    logic             endof_con;
    logic             Sin;
    logic             Dready;
    logic [WIDTH-1:0] Dout;
    logic             Dvalid;
    logic             Busy;
    logic             FrameErr;
    logic             Overrun;
`ifdef MAX11046_RX_ERRCNT_EN
    logic [7:0]       FrameErrCnt;
    logic [7:0]       OverrunCnt;
`endif

    modport master (
        output ClockEn, endof_con, Sin, Dready,
        input  Dout, Dvalid, Busy, FrameErr, Overrun
`ifdef MAX11046_RX_ERRCNT_EN
        , input FrameErrCnt, OverrunCnt
`endif
    );

    modport slave (
        input  ClockEn, endof_con, Sin, Dready,
        output Dout, Dvalid, Busy, FrameErr, Overrun
`ifdef MAX11046_RX_ERRCNT_EN
        , output FrameErrCnt, OverrunCnt
`endif
    );
endinterface

// File: rtl/max11046_serial_rx.sv
// rtl/max11046_serial_rx.sv - LSB-first serial-to-parallel receiver with one-word output register
// Optional saturating event counters are built when MAX11046_RX_ERRCNT_EN is defined.
module max11046_serial_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                    Clock,
    input  logic                    Reset,
    max11046_serial_rx_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bitcnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dvalid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_sample;
    logic             w_commit;
    logic             w_ferr;
    logic             w_consume;
    logic             w_ovr_evt;
    logic [WIDTH-1:0] w_shift_val;

    assign w_shift_val = {bus.Sin, r_shreg[WIDTH-1:1]};
    assign w_consume   = r_dvalid & bus.Dready;
    // A word landing on an unconsumed one is an overrun; a same-edge consume makes room.
    assign w_ovr_evt   = w_commit & r_dvalid & ~bus.Dready;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.endof_con) begin
                    w_state_nxt = S_SHIFT;
                    w_sample    = bus.ClockEn;
                end
            end
            S_SHIFT: begin
                if (!bus.endof_con) begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.ClockEn) begin
                    w_sample = 1'b1;
                    if (r_bitcnt == LP_LAST) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!bus.endof_con) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register and bit counter; counter restarts on frame entry and saturates at WIDTH
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else begin
            if (w_sample) begin
                r_shreg <= w_shift_val;
            end
            if (r_state == S_IDLE) begin
                r_bitcnt <= {{(CNT_W-1){1'b0}}, w_sample};
            end else if (w_sample && r_bitcnt != LP_FULL) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    // Output word register, valid/ready handshake, error pulse and sticky overrun
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_dout      <= '0;
            r_dvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            if (w_commit) begin
                r_dout   <= w_shift_val;
                r_dvalid <= 1'b1;
            end else if (w_consume) begin
                r_dvalid <= 1'b0;
            end
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.Dout     = r_dout;
    assign bus.Dvalid   = r_dvalid;
    assign bus.Busy     = (r_state != S_IDLE);
    assign bus.FrameErr = r_frame_err;
    assign bus.Overrun  = r_overrun;

`ifdef MAX11046_RX_ERRCNT_EN
    logic [7:0] r_frame_err_cnt;
    logic [7:0] r_overrun_cnt;

    // Saturating event counters for frame errors and overruns
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_frame_err_cnt <= '0;
            r_overrun_cnt   <= '0;
        end else begin
            if (w_ferr && r_frame_err_cnt != 8'hFF) begin
                r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
            end
            if (w_ovr_evt && r_overrun_cnt != 8'hFF) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end
    end

    assign bus.FrameErrCnt = r_frame_err_cnt;
    assign bus.OverrunCnt  = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_max11046_serial_rx.sv
// tb/tb_max11046_serial_rx.sv - self-checking bench for max11046_serial_rx
module tb_max11046_serial_rx;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   run      = 1'b0;
    bit   rnd_ready = 1'b0;

    max11046_serial_rx_if #(.WIDTH(16)) bus ();

    max11046_serial_rx #(.WIDTH(16), .CNT_W(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Frame-level reference: bits are placed by index into the word as they arrive.
    typedef struct {
        bit          busy;
        bit          done;
        int          bits;
        logic [15:0] word;
        logic [15:0] dout;
        bit          dvalid;
        bit          ovr;
        bit          ferr;
        int          fec;
        int          oec;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t step(model_t c, bit eoc, bit ce, bit sin, bit rdy);
        model_t n = c;
        bit commit = 1'b0;
        n.ferr = 1'b0;
        if (!c.busy) begin
            if (eoc) begin
                n.busy = 1'b1;
                n.done = 1'b0;
                n.bits = 0;
                if (ce) begin
                    n.word[0] = sin;
                    n.bits = 1;
                end
            end
        end else if (!c.done) begin
            if (!eoc) begin
                n.ferr = 1'b1;
                n.busy = 1'b0;
                if (n.fec < 255) n.fec = n.fec + 1;
            end else if (ce) begin
                n.word[c.bits] = sin;
                n.bits = c.bits + 1;
                if (n.bits == 16) begin
                    commit = 1'b1;
                    n.done = 1'b1;
                end
            end
        end else if (!eoc) begin
            n.busy = 1'b0;
        end
        if (commit) begin
            if (c.dvalid && !rdy) begin
                n.ovr = 1'b1;
                if (n.oec < 255) n.oec = n.oec + 1;
            end
            n.dout   = n.word;
            n.dvalid = 1'b1;
        end else if (c.dvalid && rdy) begin
            n.dvalid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) m <= '{default: 0};
        else       m <= step(m, bus.endof_con, bus.ClockEn, bus.Sin, bus.Dready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (run && !Reset) begin
            chk("Dout",     32'(bus.Dout),     32'(m.dout));
            chk("Dvalid",   32'(bus.Dvalid),   32'(m.dvalid));
            chk("Busy",     32'(bus.Busy),     32'(m.busy));
            chk("FrameErr", 32'(bus.FrameErr), 32'(m.ferr));
            chk("Overrun",  32'(bus.Overrun),  32'(m.ovr));
`ifdef MAX11046_RX_ERRCNT_EN
            chk("FrameErrCnt", 32'(bus.FrameErrCnt), 32'(m.fec));
            chk("OverrunCnt",  32'(bus.OverrunCnt),  32'(m.oec));
`endif
        end
    end

    task automatic drive(input bit eoc, input bit ce, input bit sin);
        @(negedge Clock);
        bus.endof_con = eoc;
        bus.ClockEn   = ce;
        bus.Sin       = sin;
        if (rnd_ready) bus.Dready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bits(input logic [15:0] w, input int lo, input int hi, input bit rand_ce);
        int i = lo;
        int guard = 0;
        bit ce;
        while (i < hi) begin
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(1'b1, ce, ce ? w[i] : 1'($urandom_range(0, 1)));
            if (ce) i++;
            guard++;
            if (guard > 2000) begin
                chk("bit_budget", 32'(guard), 32'd0);
                break;
            end
        end
    endtask

    task automatic end_frame();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_Dout"},     32'(bus.Dout),     32'd0);
        chk({tag, "_Dvalid"},   32'(bus.Dvalid),   32'd0);
        chk({tag, "_Busy"},     32'(bus.Busy),     32'd0);
        chk({tag, "_FrameErr"}, 32'(bus.FrameErr), 32'd0);
        chk({tag, "_Overrun"},  32'(bus.Overrun),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] w;
        bus.endof_con = 1'b0;
        bus.ClockEn   = 1'b0;
        bus.Sin       = 1'b0;
        bus.Dready    = 1'b1;

        // 1: reset state, then A5C3 with continuous strobes
        repeat (3) @(negedge Clock);
        chk_all_zero("reset");
        Reset = 1'b0;
        run   = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        send_bits(16'hA5C3, 0, 16, 1'b0);
        end_frame();
        chk("t1_Dout",   32'(bus.Dout),   32'h0000A5C3);
        chk("t1_Dvalid", 32'(bus.Dvalid), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("t1_consumed", 32'(bus.Dvalid), 32'd0);

        // 2: toggling ClockEn, Busy held through the frame
        send_bits(16'h8001, 0, 8, 1'b1);
        chk("t2_busy_mid", 32'(bus.Busy), 32'd1);
        send_bits(16'h8001, 8, 16, 1'b1);
        end_frame();
        chk("t2_Dout", 32'(bus.Dout), 32'h00008001);
        drive(1'b0, 1'b0, 1'b0);

        // 3: short frame of 9 bits, then a good 1234 frame
        send_bits(16'hBEEF, 0, 9, 1'b0);
        end_frame();
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_ferr_hi", 32'(bus.FrameErr), 32'd1);
        chk("t3_idle",    32'(bus.Busy),     32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_ferr_lo", 32'(bus.FrameErr), 32'd0);
        chk("t3_dvalid",  32'(bus.Dvalid),   32'd0);
        send_bits(16'h1234, 0, 16, 1'b0);
        end_frame();
        chk("t3_Dout", 32'(bus.Dout), 32'h00001234);
        drive(1'b0, 1'b0, 1'b0);

        // 4: overrun with consumer stalled
        bus.Dready = 1'b0;
        send_bits(16'h0001, 0, 16, 1'b0);
        end_frame();
        drive(1'b0, 1'b0, 1'b0);
        send_bits(16'hFFFF, 0, 16, 1'b0);
        end_frame();
        chk("t4_Dout",    32'(bus.Dout),    32'h0000FFFF);
        chk("t4_Overrun", 32'(bus.Overrun), 32'd1);
        bus.Dready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_dvalid",  32'(bus.Dvalid),  32'd0);
        chk("t4_sticky",  32'(bus.Overrun), 32'd1);

        // 5: reset mid-frame, then 5A5A
        send_bits(16'h3C3C, 0, 7, 1'b0);
        chk("t5_busy", 32'(bus.Busy), 32'd1);
        #2 Reset = 1'b1;
        #1 chk_all_zero("t5_async");
        bus.endof_con = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        send_bits(16'h5A5A, 0, 16, 1'b0);
        end_frame();
        chk("t5_Dout", 32'(bus.Dout), 32'h00005A5A);
        drive(1'b0, 1'b0, 1'b0);

        // Randomized frames, lengths, strobes and consumer readiness
        rnd_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            w = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            send_bits(w, 0, n, 1'b1);
            repeat ($urandom_range(0, 2)) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end_frame();
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_ready  = 1'b0;
        bus.Dready = 1'b1;

`ifdef MAX11046_RX_ERRCNT_EN
        // 6: error counter saturation and reset clear
        for (int k = 0; k < 300; k++) begin
            send_bits(16'h0000, 0, 2, 1'b0);
            end_frame();
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("t6_fec_sat", 32'(bus.FrameErrCnt), 32'h000000FF);
        #2 Reset = 1'b1;
        #1 chk("t6_fec_clr", 32'(bus.FrameErrCnt), 32'd0);
        chk("t6_oec_clr", 32'(bus.OverrunCnt), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
`endif

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
